// File: rtl/accel_pkg.sv
// Shared types and helpers for the accelerator datapath blocks.
package accel_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} drain_state_t;

  // A zero length still makes progress, so it is promoted to one beat.
  function automatic int unsigned clamp_burst(input int unsigned len,
                                              input int unsigned max_burst);
    if (len == 0) return 1;
    if (len > max_burst) return max_burst;
    return len;
  endfunction

endpackage

// File: rtl/fifo_burst_drain.sv
// Pops a job's worth of FIFO words and writes them out as address-incrementing bursts.
// Optional FIFO_BURST_DRAIN_STATS_EN adds a FIFO underrun stall counter.
module fifo_burst_drain
  import accel_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MAX_BURST   = 16,
  parameter int COUNT_WIDTH = 16,
  localparam int LW = $clog2(MAX_BURST + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] total_words,
  input  logic [LW-1:0]          burst_len,
  output logic                   busy,
  output logic                   done,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [LW-1:0]          mem_len,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  output logic                   mem_wvalid,
  input  logic                   mem_wready,
  output logic                   mem_wlast
`ifdef FIFO_BURST_DRAIN_STATS_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int BYTES = DATA_WIDTH / 8;

  drain_state_t           state, next_state;
  logic [ADDR_WIDTH-1:0]  cur_addr;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [LW-1:0]          blen, beat, blen_clamp;
  logic                   xfer, last_beat;

  function automatic logic [LW-1:0] len_for(input logic [COUNT_WIDTH-1:0] rem,
                                            input logic [LW-1:0] b);
    return (rem < COUNT_WIDTH'(b)) ? LW'(rem) : b;
  endfunction

  assign blen_clamp = LW'(clamp_burst(32'(burst_len), 32'(MAX_BURST)));
  assign xfer       = (state == DATA) && in_valid && mem_wready;
  assign last_beat  = (beat == mem_len - LW'(1));
  assign mem_addr   = cur_addr;
  assign mem_wdata  = in_data;

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else       state <= next_state;

  always_comb begin
    next_state    = state;
    busy          = 1'b0;
    done          = 1'b0;
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    mem_wvalid    = 1'b0;
    mem_wlast     = 1'b0;
    case (state)
      IDLE: if (start) next_state = (total_words == '0) ? DONE : REQ;
      REQ: begin
        busy          = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) next_state = DATA;
      end
      DATA: begin
        busy       = 1'b1;
        mem_wvalid = in_valid;
        in_ready   = mem_wready;
        mem_wlast  = last_beat;
        if (xfer && last_beat)
          next_state = (remaining == COUNT_WIDTH'(mem_len)) ? DONE : REQ;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // mem_len is settled on the way into REQ so it is stable for the whole request.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cur_addr  <= '0;
      remaining <= '0;
      blen      <= '0;
      mem_len   <= '0;
      beat      <= '0;
    end else if (state == IDLE && start) begin
      cur_addr  <= base_addr;
      remaining <= total_words;
      blen      <= blen_clamp;
      mem_len   <= len_for(total_words, blen_clamp);
      beat      <= '0;
    end else if (state == REQ && mem_req_ready) begin
      beat <= '0;
    end else if (xfer) begin
      if (last_beat) begin
        remaining <= remaining - COUNT_WIDTH'(mem_len);
        cur_addr  <= cur_addr + ADDR_WIDTH'(mem_len) * ADDR_WIDTH'(BYTES);
        mem_len   <= len_for(remaining - COUNT_WIDTH'(mem_len), blen);
        beat      <= '0;
      end else begin
        beat <= beat + LW'(1);
      end
    end

`ifdef FIFO_BURST_DRAIN_STATS_EN
  always_ff @(posedge clock or posedge reset)
    if (reset)
      stall_cycles <= '0;
    else if (state == IDLE && start)
      stall_cycles <= '0;
    else if (state == DATA && mem_wready && !in_valid && stall_cycles != '1)
      stall_cycles <= stall_cycles + 32'd1;
`endif

endmodule
